// File: rtl/pyramid_level_arbiter_if.sv
// Per-level pixel inputs and the merged, level-tagged pixel output of the pyramid arbiter.
// The slave modport is the arbiter's view; the master modport is the view of whatever drives it.
interface pyramid_level_arbiter_if #(
  parameter int DATA_WIDTH = 8,
  parameter int LEVELS     = 15,
  parameter int LEVEL_BITS = 4
);
  logic [LEVELS-1:0]            in_valid;
  logic [DATA_WIDTH*LEVELS-1:0] pyramid_pixels;
  logic [LEVELS-1:0]            in_ready;
  logic                         out_valid;
  logic                         out_ready;
  logic [DATA_WIDTH-1:0]        out_pixel;
  logic [LEVEL_BITS-1:0]        out_level;

  modport slave (
    input  in_valid, pyramid_pixels, out_ready,
    output in_ready, out_valid, out_pixel, out_level
  );

  modport master (
    output in_valid, pyramid_pixels, out_ready,
    input  in_ready, out_valid, out_pixel, out_level
  );
endinterface

// File: rtl/pyramid_level_arbiter.sv
// Round-robin burst arbiter merging per-level pyramid pixel streams into one registered,
// level-tagged stream; a granted level keeps ownership for up to BURST beats.
module pyramid_level_arbiter #(
  parameter int DATA_WIDTH = 8,
  parameter int LEVELS     = 15,
  parameter int LEVEL_BITS = 4,
  parameter int BURST      = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  pyramid_level_arbiter_if.slave bus
);

  localparam int CNT_BITS = $clog2(BURST) + 1;

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_BURST = 1'b1;

  logic [0:0]            state;
  logic [LEVEL_BITS-1:0] cur;
  logic [LEVEL_BITS-1:0] ptr;
  logic [CNT_BITS-1:0]   cnt;

  logic                  load_en;
  logic                  win_found;
  logic [LEVEL_BITS-1:0] win;
  logic [LEVEL_BITS-1:0] sel;
  logic                  xfer;
  int                    idx;

  // Increment that wraps at LEVELS-1 so a non-power-of-two LEVELS never yields an out-of-range index.
  function automatic logic [LEVEL_BITS-1:0] next_level(input logic [LEVEL_BITS-1:0] l);
    return (int'(l) == LEVELS - 1) ? '0 : l + 1'b1;
  endfunction

  always_comb begin
    // NOTE: every output of this block gets a default first so no path leaves one unassigned (no latch).
    load_en   = !bus.out_valid || bus.out_ready;
    win_found = 1'b0;
    win       = '0;
    idx       = 0;
    bus.in_ready = '0;

    for (int k = 0; k < LEVELS; k++) begin
      idx = int'(ptr) + k;
      if (idx >= LEVELS) idx = idx - LEVELS;
      if (!win_found && bus.in_valid[idx]) begin
        win_found = 1'b1;
        win       = LEVEL_BITS'(idx);
      end
    end

    if (!rst) begin
      if (state == S_IDLE) begin
        if (win_found) bus.in_ready[win] = load_en;
      end else begin
        bus.in_ready[cur] = load_en;
      end
    end

    sel  = (state == S_IDLE) ? win : cur;
    xfer = |(bus.in_valid & bus.in_ready);
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.out_valid <= 1'b0;
      bus.out_pixel <= '0;
      bus.out_level <= '0;
      state         <= S_IDLE;
      cur           <= '0;
      cnt           <= '0;
      ptr           <= '0;
    end else begin
      if (load_en) begin
        bus.out_valid <= xfer;
        if (xfer) begin
          bus.out_pixel <= bus.pyramid_pixels[sel*DATA_WIDTH +: DATA_WIDTH];
          bus.out_level <= sel;
        end
      end

      if (state == S_IDLE) begin
        if (xfer) begin
          cur <= win;
          cnt <= CNT_BITS'(1);
          if (BURST == 1) ptr <= next_level(win);
          else            state <= S_BURST;
        end
      end else begin
        if (xfer) begin
          if (cnt == CNT_BITS'(BURST - 1)) begin
            ptr   <= next_level(cur);
            state <= S_IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end else if (!bus.in_valid[cur] && load_en) begin
          // Owner dropped valid: give up the grant, costing one bubble cycle.
          ptr   <= next_level(cur);
          state <= S_IDLE;
        end
      end
    end
  end

endmodule

// File: tb/tb_pyramid_level_arbiter.sv
// Directed bench for pyramid_level_arbiter with 4 levels, burst of 2 and 8-bit pixels.
// Each level is a simple counting source: src_left beats remaining, src_data next pixel.
module tb_pyramid_level_arbiter;

  localparam int DW = 8;
  localparam int NL = 4;
  localparam int LB = 2;
  localparam int BR = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;

  int total = 0;
  int bad   = 0;

  int         src_left [NL];
  logic [7:0] src_data [NL];

  pyramid_level_arbiter_if #(.DATA_WIDTH(DW), .LEVELS(NL), .LEVEL_BITS(LB)) bus ();

  pyramid_level_arbiter #(
    .DATA_WIDTH(DW), .LEVELS(NL), .LEVEL_BITS(LB), .BURST(BR)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp_v);
    total++;
    if (act !== exp_v) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp_v);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < NL; i++) begin
      bus.in_valid[i]                = (src_left[i] != 0);
      bus.pyramid_pixels[i*DW +: DW] = src_data[i];
    end
  endtask

  // One clock: record handshakes before the edge, retire accepted beats, re-drive, let comb settle.
  task automatic tick();
    logic [NL-1:0] fire;
    fire = bus.in_valid & bus.in_ready;
    @(posedge clk);
    #1;
    for (int i = 0; i < NL; i++) begin
      if (fire[i]) begin
        src_left[i]--;
        src_data[i]++;
      end
    end
    drive();
    #1;
  endtask

  task automatic do_reset();
    for (int i = 0; i < NL; i++) begin
      src_left[i] = 0;
      src_data[i] = '0;
    end
    drive();
    bus.out_ready = 1'b1;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    #1;
  endtask

  initial begin
    int exp_lv [10];
    exp_lv = '{0, 0, 1, 1, 2, 2, 3, 3, 0, 0};

    for (int i = 0; i < NL; i++) begin
      src_left[i] = 100;
      src_data[i] = 8'(8'h80 + i);
    end
    bus.out_ready = 1'b1;
    rst = 1'b1;
    drive();
    #2;

    // Reset with all levels requesting
    check("rst_in_ready_0", 32'(bus.in_ready), 32'h0);
    for (int k = 0; k < 3; k++) begin
      tick();
      check("rst_in_ready", 32'(bus.in_ready), 32'h0);
      check("rst_out_valid", 32'(bus.out_valid), 32'h0);
    end
    check("rst_out_pixel", 32'(bus.out_pixel), 32'h0);
    check("rst_out_level", 32'(bus.out_level), 32'h0);
    rst = 1'b0;
    #1;
    check("rst_first_grant", 32'(bus.in_ready), 32'h1);
    tick();
    check("rst_first_valid", 32'(bus.out_valid), 32'h1);
    check("rst_first_level", 32'(bus.out_level), 32'h0);
    check("rst_first_pixel", 32'(bus.out_pixel), 32'h80);

    // Reset mid-burst drops the in-flight beat
    rst = 1'b1;
    tick();
    check("midrst_out_valid", 32'(bus.out_valid), 32'h0);
    check("midrst_ptr", 32'(dut.ptr), 32'h0);

    // Single stream on level 2
    do_reset();
    src_left[2] = 4;
    src_data[2] = 8'h10;
    drive();
    #1;
    check("single_grant", 32'(bus.in_ready), 32'h4);
    for (int k = 0; k < 4; k++) begin
      tick();
      check("single_valid", 32'(bus.out_valid), 32'h1);
      check("single_pixel", 32'(bus.out_pixel), 32'(8'h10 + k));
      check("single_level", 32'(bus.out_level), 32'h2);
    end
    tick();
    check("single_drain", 32'(bus.out_valid), 32'h0);

    // Full contention: two beats per level, no gaps
    do_reset();
    for (int i = 0; i < NL; i++) src_left[i] = 100;
    drive();
    #1;
    for (int k = 0; k < 10; k++) begin
      tick();
      check("contend_valid", 32'(bus.out_valid), 32'h1);
      check("contend_level", 32'(bus.out_level), 32'(exp_lv[k]));
    end

    // Backpressure mid-burst on level 1
    do_reset();
    src_left[1] = 2;
    src_data[1] = 8'h20;
    drive();
    #1;
    tick();
    check("bp_first_pixel", 32'(bus.out_pixel), 32'h20);
    bus.out_ready = 1'b0;
    #1;
    for (int k = 0; k < 3; k++) begin
      check("bp_in_ready", 32'(bus.in_ready), 32'h0);
      tick();
      check("bp_valid_hold", 32'(bus.out_valid), 32'h1);
      check("bp_pixel_hold", 32'(bus.out_pixel), 32'h20);
      check("bp_level_hold", 32'(bus.out_level), 32'h1);
      check("bp_cnt_hold", 32'(dut.cnt), 32'h1);
    end
    bus.out_ready = 1'b1;
    #1;
    check("bp_resume_ready", 32'(bus.in_ready), 32'h2);
    tick();
    check("bp_second_pixel", 32'(bus.out_pixel), 32'h21);
    check("bp_second_level", 32'(bus.out_level), 32'h1);
    check("bp_ptr_after", 32'(dut.ptr), 32'h2);
    tick();
    check("bp_drain", 32'(bus.out_valid), 32'h0);

    // Owner dries up after one beat; level 3 takes over after one bubble
    do_reset();
    src_left[1] = 1;
    src_data[1] = 8'h30;
    src_left[3] = 100;
    src_data[3] = 8'h40;
    drive();
    #1;
    tick();
    check("dry_first_level", 32'(bus.out_level), 32'h1);
    check("dry_first_pixel", 32'(bus.out_pixel), 32'h30);
    tick();
    check("dry_bubble", 32'(bus.out_valid), 32'h0);
    tick();
    check("dry_l3_valid0", 32'(bus.out_valid), 32'h1);
    check("dry_l3_level0", 32'(bus.out_level), 32'h3);
    check("dry_l3_pixel0", 32'(bus.out_pixel), 32'h40);
    tick();
    check("dry_l3_level1", 32'(bus.out_level), 32'h3);
    check("dry_l3_pixel1", 32'(bus.out_pixel), 32'h41);
    check("dry_ptr_after", 32'(dut.ptr), 32'h0);

    // Wrap: move ptr to 3, then only level 0 requests
    do_reset();
    src_left[2] = 2;
    src_data[2] = 8'h60;
    drive();
    #1;
    tick();
    tick();
    check("wrap_ptr_at3", 32'(dut.ptr), 32'h3);
    src_left[0] = 2;
    src_data[0] = 8'h50;
    drive();
    #1;
    check("wrap_grant0", 32'(bus.in_ready), 32'h1);
    tick();
    check("wrap_level0", 32'(bus.out_level), 32'h0);
    check("wrap_pixel0", 32'(bus.out_pixel), 32'h50);
    tick();
    check("wrap_level1", 32'(bus.out_level), 32'h0);
    check("wrap_pixel1", 32'(bus.out_pixel), 32'h51);
    check("wrap_ptr_after", 32'(dut.ptr), 32'h1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
